seg7_readback_decoder: RTL

- Receive-side counterpart to the team's 2-bit calculator / 7-segment encoder tiles.
- Samples a 7-segment pattern bus (bit 0 = segment a ... bit 6 = segment g), debounces it, and classifies each settled pattern as hex digit, blank, minus, or invalid.
- Reports each accepted result with a one-cycle strobe and keeps saturating error and glitch statistics.
- Used for on-chip self-check of display encoders and as a readback path for display-driving tiles.

---
 rtl/seg7_readback_decoder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/seg7_readback_decoder.sv
// Debounces a 7-segment pattern bus and classifies each settled pattern as
// hex digit, blank, minus or invalid, with saturating error/glitch statistics.
//
// state  | meaning
// SETTLE | candidate pattern is being counted towards acceptance
// LOCKED | candidate accepted; waiting for the bus to change
module seg7_readback_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       sample_en,
    output logic       valid_out,
    output logic [3:0] value_out,
    output logic [1:0] kind_out,
    output logic       locked,
    output logic [7:0] err_count,
    output logic [7:0] glitch_count
);

    typedef enum logic {SETTLE, LOCKED} state_t;

    localparam logic [7:0] ACCEPT_CNT = 8'(STABLE_CYCLES - 1);
    localparam logic [1:0] KIND_DIGIT = 2'b00;
    localparam logic [1:0] KIND_BLANK = 2'b01;
    localparam logic [1:0] KIND_MINUS = 2'b10;
    localparam logic [1:0] KIND_INVAL = 2'b11;

    state_t     r_state;
    logic [6:0] r_s;
    logic [6:0] r_cand;
    logic [7:0] r_cnt;
    logic       r_valid;
    logic [3:0] r_value;
    logic [1:0] r_kind;
    logic [7:0] r_err;
    logic [7:0] r_glitch;

    logic [6:0] w_seg;
    logic [5:0] w_dec;
    logic       w_change;

    // Returns {kind, value} for a gfedcba pattern.
    function automatic logic [5:0] f_decode(input logic [6:0] p);
        logic [5:0] d;
        d = {KIND_INVAL, 4'h0};
        case (p)
            7'h3F: d = {KIND_DIGIT, 4'h0};
            7'h06: d = {KIND_DIGIT, 4'h1};
            7'h5B: d = {KIND_DIGIT, 4'h2};
            7'h4F: d = {KIND_DIGIT, 4'h3};
            7'h66: d = {KIND_DIGIT, 4'h4};
            7'h6D: d = {KIND_DIGIT, 4'h5};
            7'h7D: d = {KIND_DIGIT, 4'h6};
            7'h07: d = {KIND_DIGIT, 4'h7};
            7'h7F: d = {KIND_DIGIT, 4'h8};
            7'h6F: d = {KIND_DIGIT, 4'h9};
            7'h77: d = {KIND_DIGIT, 4'hA};
            7'h7C: d = {KIND_DIGIT, 4'hB};
            7'h39: d = {KIND_DIGIT, 4'hC};
            7'h5E: d = {KIND_DIGIT, 4'hD};
            7'h79: d = {KIND_DIGIT, 4'hE};
            7'h71: d = {KIND_DIGIT, 4'hF};
            7'h00: d = {KIND_BLANK, 4'h0};
            7'h40: d = {KIND_MINUS, 4'h0};
            default: d = {KIND_INVAL, 4'h0};
        endcase
        return d;
    endfunction

    assign w_seg    = ACTIVE_LOW ? ~seg_in : seg_in;
    assign w_dec    = f_decode(r_cand);
    assign w_change = (r_s != r_cand);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= SETTLE;
            r_s      <= 7'h00;
            r_cand   <= 7'h00;
            r_cnt    <= 8'h00;
            r_valid  <= 1'b0;
            r_value  <= 4'h0;
            r_kind   <= 2'b00;
            r_err    <= 8'h00;
            r_glitch <= 8'h00;
        end else begin
            r_s     <= w_seg;
            r_valid <= 1'b0;
            if (sample_en) begin
                case (r_state)
                    SETTLE: begin
                        if (w_change) begin
                            r_cand <= r_s;
                            r_cnt  <= 8'h01;
                            // A nonzero count means a candidate was abandoned.
                            if (r_cnt != 8'h00 && r_glitch != 8'hFF)
                                r_glitch <= r_glitch + 8'h01;
                        end else if (r_cnt < ACCEPT_CNT) begin
                            r_cnt <= r_cnt + 8'h01;
                        end else begin
                            r_state <= LOCKED;
                            r_valid <= 1'b1;
                            r_kind  <= w_dec[5:4];
                            r_value <= w_dec[3:0];
                            if (w_dec[5:4] == KIND_INVAL && r_err != 8'hFF)
                                r_err <= r_err + 8'h01;
                        end
                    end
                    LOCKED: begin
                        if (w_change) begin
                            r_state <= SETTLE;
                            r_cand  <= r_s;
                            r_cnt   <= 8'h01;
                        end
                    end
                endcase
            end
        end
    end

    assign valid_out    = r_valid;
    assign value_out    = r_value;
    assign kind_out     = r_kind;
    assign locked       = (r_state == LOCKED);
    assign err_count    = r_err;
    assign glitch_count = r_glitch;

endmodule
